// File: rtl/instr_sequencer.sv
// instr_sequencer
//   Per-instruction control FSM for the bytecode core. Each instruction runs
//   through these steps:
//     fetch opcode -> fetch inline args -> pop operands -> execute ->
//     write back -> update PC.
//   The registered opcode drives an external combinational decoder. This
//   block consumes the decoder's argc/stackargs/stackwb/isgoto/iscmp outputs.
//
// Ports
//   clk_i, rst_i             clock, asynchronous active-high reset
//   start_i                  begin at RESET_PC (only honoured in IDLE/HALT)
//   prog_addr_o/prog_rd_o    program memory read; prog_data_i valid next cycle
//   opcode_o                 registered opcode to the decoder
//   argc_i .. iscmp_i        decoder results for opcode_o
//   cmp_true_i               branch condition, valid with exec_done_i
//   arg_o                    inline argument bytes, big-endian
//   stack_*                  operand stack status and pop/push strobes
//   opnd0_o..opnd2_o         popped operands (opnd0 = last popped)
//   exec_start_o/exec_done_i execution-unit handshake; exec_result_i is pushed
//   busy_o, halted_o, error_o  status; error is sticky until rst or start
module instr_sequencer #(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  output logic [PC_W-1:0] prog_addr_o,
  output logic            prog_rd_o,
  input  logic [7:0]      prog_data_i,
  output logic [7:0]      opcode_o,
  input  logic [1:0]      argc_i,
  input  logic [1:0]      stackargs_i,
  input  logic            stackwb_i,
  input  logic            isgoto_i,
  input  logic            iscmp_i,
  input  logic            cmp_true_i,
  output logic [15:0]     arg_o,
  input  logic [31:0]     stack_top_i,
  input  logic            stack_empty_i,
  input  logic            stack_full_i,
  output logic            stack_pop_o,
  output logic            stack_push_o,
  output logic [31:0]     push_data_o,
  output logic [31:0]     opnd0_o,
  output logic [31:0]     opnd1_o,
  output logic [31:0]     opnd2_o,
  output logic            exec_start_o,
  input  logic            exec_done_i,
  input  logic [31:0]     exec_result_i,
  output logic            busy_o,
  output logic            halted_o,
  output logic            error_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_LATCH, S_AFETCH, S_ALATCH, S_POP, S_EXEC, S_WB, S_HALT
  } state_t;

  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

  state_t          state_q, cur;
  logic            disp_q;      // first cycle after LATCH: route on decoder
  logic [PC_W-1:0] pc_q, ipc_q;
  logic [7:0]      opcode_q;
  logic [15:0]     arg_q;
  logic [31:0]     opnd0_q, opnd1_q, opnd2_q;
  logic [1:0]      cnt_q;
  logic            exec_wait_q, cmp_q, error_q;

  logic [1:0]      argc_eff;
  logic [31:0]     arg_sx;
  logic [PC_W-1:0] pc_br;
  logic            take_br;

  // The opcode is only registered at the end of LATCH, so the decoder result
  // is not known until the cycle after. That cycle acts directly as the
  // first AFETCH, POP or EXEC cycle, which keeps the minimum instruction
  // latency at FETCH, LATCH, EXEC, WB.
  always_comb begin
    argc_eff = (argc_i == 2'd3) ? 2'd2 : argc_i;
    cur      = state_q;
    if (disp_q) begin
      if (argc_eff != 2'd0)         cur = S_AFETCH;
      else if (stackargs_i != 2'd0) cur = S_POP;
      else                          cur = S_EXEC;
    end
  end

  assign arg_sx  = {{16{arg_q[15]}}, arg_q};
  assign pc_br   = ipc_q + arg_sx[PC_W-1:0];
  assign take_br = isgoto_i | (iscmp_i & cmp_q);

  assign prog_addr_o  = pc_q;
  assign prog_rd_o    = (cur == S_FETCH) || (cur == S_AFETCH);
  assign stack_pop_o  = (cur == S_POP) && !stack_empty_i;
  assign stack_push_o = (cur == S_WB) && stackwb_i && !stack_full_i;
  assign exec_start_o = (cur == S_EXEC) && !exec_wait_q;
  assign push_data_o  = exec_result_i;
  assign opcode_o     = opcode_q;
  assign arg_o        = arg_q;
  assign opnd0_o      = opnd0_q;
  assign opnd1_o      = opnd1_q;
  assign opnd2_o      = opnd2_q;
  assign busy_o       = (cur != S_IDLE) && (cur != S_HALT);
  assign halted_o     = (cur == S_HALT);
  assign error_o      = error_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      disp_q      <= 1'b0;
      pc_q        <= RESET_PC;
      ipc_q       <= RESET_PC;
      opcode_q    <= 8'h00;
      arg_q       <= 16'h0000;
      opnd0_q     <= 32'h0;
      opnd1_q     <= 32'h0;
      opnd2_q     <= 32'h0;
      cnt_q       <= 2'd0;
      exec_wait_q <= 1'b0;
      cmp_q       <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q <= cur;
      disp_q  <= 1'b0;
      case (cur)
        S_IDLE, S_HALT: begin
          if (start_i) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            error_q <= 1'b0;
          end
        end
        S_FETCH: begin
          ipc_q   <= pc_q;
          state_q <= S_LATCH;
        end
        S_LATCH: begin
          opcode_q <= prog_data_i;
          pc_q     <= pc_q + PC_ONE;
          arg_q    <= 16'h0000;
          cnt_q    <= 2'd0;
          // Return opcodes end the program.
          if (prog_data_i inside {8'hac, 8'hb0, 8'hb1}) begin
            state_q <= S_HALT;
          end else begin
            state_q <= S_AFETCH;
            disp_q  <= 1'b1;
          end
        end
        S_AFETCH: state_q <= S_ALATCH;
        S_ALATCH: begin
          arg_q <= {arg_q[7:0], prog_data_i};
          pc_q  <= pc_q + PC_ONE;
          if ((cnt_q + 2'd1) < argc_eff) begin
            cnt_q   <= cnt_q + 2'd1;
            state_q <= S_AFETCH;
          end else begin
            cnt_q   <= 2'd0;
            state_q <= (stackargs_i != 2'd0) ? S_POP : S_EXEC;
          end
        end
        S_POP: begin
          if (stack_empty_i) begin
            error_q <= 1'b1;
            state_q <= S_HALT;
          end else begin
            opnd2_q <= opnd1_q;
            opnd1_q <= opnd0_q;
            opnd0_q <= stack_top_i;
            if ((cnt_q + 2'd1) == stackargs_i) begin
              cnt_q   <= 2'd0;
              state_q <= S_EXEC;
            end else begin
              cnt_q <= cnt_q + 2'd1;
            end
          end
        end
        S_EXEC: begin
          exec_wait_q <= 1'b1;
          if (exec_done_i) begin
            cmp_q       <= cmp_true_i;
            exec_wait_q <= 1'b0;
            state_q     <= S_WB;
          end
        end
        S_WB: begin
          if (stackwb_i && stack_full_i) begin
            error_q <= 1'b1;
            state_q <= S_HALT;
          end else begin
            if (take_br) pc_q <= pc_br;
            state_q <= S_FETCH;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
